poly_coeff_collector: RTL and testbench

- Stream sink for the modular-arithmetic datapath. Sits at the output side of the polynomial adder (or any other coefficient-per-clock stage).
- Consumes coefficients over the valid/ready interface and stores them in order into an N-entry buffer. Declares the polynomial complete after N beats.
- Exposes the stored polynomial through a 1-cycle-latency random-access read port until software/control releases it for refill.

---
 rtl/poly_coeff_collector_if.sv | 39 +++
 rtl/poly_coeff_collector.sv | 137 +++++++++++++
 tb/tb_poly_coeff_collector.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/poly_coeff_collector_if.sv
// Coefficient stream + random-access read bundle for poly_coeff_collector.
// POLY_COLLECTOR_RANGE_CHECK_EN adds the range_err_o status line.
interface poly_coeff_collector_if #(
  parameter int logq = 5,
  parameter int logN = 3
);
  logic            in_valid_i;
  logic [logq-1:0] in_data_i;
  logic            in_ready_o;
  logic            flush_i;
  logic            release_i;
  logic            poly_done_o;
  logic [logN:0]   count_o;
  logic            rd_en_i;
  logic [logN-1:0] rd_addr_i;
  logic [logq-1:0] rd_data_o;
  logic            rd_valid_o;
`ifdef POLY_COLLECTOR_RANGE_CHECK_EN
  logic            range_err_o;

  modport master (
    output in_valid_i, in_data_i, flush_i, release_i, rd_en_i, rd_addr_i,
    input  in_ready_o, poly_done_o, count_o, rd_data_o, rd_valid_o, range_err_o
  );
  modport slave (
    input  in_valid_i, in_data_i, flush_i, release_i, rd_en_i, rd_addr_i,
    output in_ready_o, poly_done_o, count_o, rd_data_o, rd_valid_o, range_err_o
  );
`else
  modport master (
    output in_valid_i, in_data_i, flush_i, release_i, rd_en_i, rd_addr_i,
    input  in_ready_o, poly_done_o, count_o, rd_data_o, rd_valid_o
  );
  modport slave (
    input  in_valid_i, in_data_i, flush_i, release_i, rd_en_i, rd_addr_i,
    output in_ready_o, poly_done_o, count_o, rd_data_o, rd_valid_o
  );
`endif
endinterface

// File: rtl/poly_coeff_collector.sv
// Collects N coefficients into a buffer, then holds them for random-access reads until released.
// Optional macro POLY_COLLECTOR_RANGE_CHECK_EN adds a sticky range_err_o flag for beats >= q.
module poly_coeff_collector #(
  parameter int q    = 17,
  parameter int N    = 8,
  parameter int logq = 5,
  parameter int logN = 3
) (
  input logic                   clk,
  input logic                   reset_n,
  poly_coeff_collector_if.slave bus
);
  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  localparam logic [logN:0] LAST_IDX = (logN + 1)'(N - 1);
  localparam logic [logN:0] ONE      = (logN + 1)'(1);

  state_t          state_q, state_d;
  logic [logN:0]   count_q, count_d;
  logic            poly_done_q, poly_done_d;
  logic [logq-1:0] rd_data_q;
  logic            rd_valid_q;
  logic            in_ready;
  logic            accept;
  logic            last_beat;
  logic            reopen;

  logic [logq-1:0] coeff_mem [N];

  assign accept    = bus.in_valid_i && in_ready;
  assign last_beat = accept && (count_q == LAST_IDX);
  assign reopen    = (state_q == FULL) && bus.release_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL:    if (last_beat)   state_d = FULL;
        FULL:    if (bus.release_i) state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  // in_ready depends only on state and flush, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    if (state_q == FILL && !bus.flush_i) begin
      in_ready = 1'b1;
    end
  end

  always_comb begin
    count_d     = count_q;
    poly_done_d = poly_done_q;
    if (bus.flush_i || reopen) begin
      count_d     = '0;
      poly_done_d = 1'b0;
    end else if (accept) begin
      count_d = count_q + ONE;
      if (last_beat) begin
        poly_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      poly_done_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      poly_done_q <= poly_done_d;
    end
  end

  // Buffer has no reset so it maps onto block RAM; stale contents are allowed.
  always_ff @(posedge clk) begin
    if (accept) begin
      coeff_mem[count_q[logN-1:0]] <= bus.in_data_i;
    end
  end

  // Registered read sees the pre-write value on a same-cycle collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_en_i;
      if (bus.rd_en_i) begin
        rd_data_q <= coeff_mem[bus.rd_addr_i];
      end
    end
  end

`ifdef POLY_COLLECTOR_RANGE_CHECK_EN
  localparam logic [logq:0] Q_VAL = (logq + 1)'(q);

  logic range_err_q, range_err_d;

  always_comb begin
    range_err_d = range_err_q;
    if (bus.flush_i || reopen) begin
      range_err_d = 1'b0;
    end else if (accept && ({1'b0, bus.in_data_i} >= Q_VAL)) begin
      range_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= range_err_d;
    end
  end

  assign bus.range_err_o = range_err_q;
`endif

  assign bus.in_ready_o  = in_ready;
  assign bus.poly_done_o = poly_done_q;
  assign bus.count_o     = count_q;
  assign bus.rd_data_o   = rd_data_q;
  assign bus.rd_valid_o  = rd_valid_q;
endmodule

// File: tb/tb_poly_coeff_collector.sv
// Directed, table-driven bench for poly_coeff_collector (q=17, N=8) plus hand-written reset sequence.
module tb_poly_coeff_collector;
  logic clk;
  logic reset_n;

  poly_coeff_collector_if #(.logq(5), .logN(3)) bus ();

  poly_coeff_collector #(.q(17), .N(8), .logq(5), .logN(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       in_valid;
    logic [4:0] in_data;
    logic       flush;
    logic       rel;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic       exp_ready;
    logic [3:0] exp_count;
    logic       exp_done;
    logic       chk_rd;
    logic [4:0] exp_rd_data;
  } vec_t;

  vec_t vecs[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic void add(input string nm, input logic v, input logic [4:0] d,
                              input logic fl, input logic rl, input logic re,
                              input logic [2:0] ra, input logic er, input logic [3:0] ec,
                              input logic ed, input logic cr, input logic [4:0] erd);
    vec_t t;
    t.name = nm; t.in_valid = v; t.in_data = d; t.flush = fl; t.rel = rl;
    t.rd_en = re; t.rd_addr = ra; t.exp_ready = er; t.exp_count = ec;
    t.exp_done = ed; t.chk_rd = cr; t.exp_rd_data = erd;
    vecs.push_back(t);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = '0;
    bus.flush_i    = 1'b0;
    bus.release_i  = 1'b0;
    bus.rd_en_i    = 1'b0;
    bus.rd_addr_i  = '0;
  endtask

  task automatic apply(input int idx, input vec_t t);
    @(negedge clk);
    bus.in_valid_i = t.in_valid;
    bus.in_data_i  = t.in_data;
    bus.flush_i    = t.flush;
    bus.release_i  = t.rel;
    bus.rd_en_i    = t.rd_en;
    bus.rd_addr_i  = t.rd_addr;
    #1;
    check({t.name, ".in_ready"}, bus.in_ready_o, t.exp_ready);
    @(posedge clk);
    #1;
    check({t.name, ".count"}, bus.count_o, t.exp_count);
    check({t.name, ".poly_done"}, bus.poly_done_o, t.exp_done);
    check({t.name, ".rd_valid"}, bus.rd_valid_o, t.rd_en);
    if (t.chk_rd) check({t.name, ".rd_data"}, bus.rd_data_o, t.exp_rd_data);
    $display("[TB] vec %0d %s v=%0d d=%0d fl=%0d rel=%0d rd=%0d@%0d -> cnt=%0d done=%0d rdat=%0d",
             idx, t.name, t.in_valid, t.in_data, t.flush, t.rel, t.rd_en, t.rd_addr,
             bus.count_o, bus.poly_done_o, bus.rd_data_o);
  endtask

  initial begin
    logic [4:0] fill_vals [8];
    fill_vals = '{5'd0, 5'd3, 5'd16, 5'd5, 5'd9, 5'd12, 5'd1, 5'd7};

    // Back-to-back fill, then stall with data 4 held while reading everything back.
    for (int i = 0; i < 8; i++)
      add("fill", 1, fill_vals[i], 0, 0, 0, 0, 1, 4'(i + 1), i == 7, 0, 0);
    for (int k = 0; k < 8; k++)
      add("stall_read", 1, 4, 0, 0, 1, 3'(k), 0, 8, 1, 1, fill_vals[k]);
    add("release", 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add("refill", 1, 4, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    add("read_idx0", 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 4);
    add("rel_in_fill", 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    add("flush", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Gapped input: beats 2,4,..,16 on even cycles, idle (data 31) on odd cycles.
    for (int c = 0; c < 16; c++) begin
      if (c % 2 == 0)
        add("gap_v", 1, 5'(c + 2), 0, 0, 0, 0, 1, 4'(c / 2 + 1), c == 14, 0, 0);
      else
        add("gap_idle", 0, 31, 0, 0, 0, 0, c != 15, 4'((c - 1) / 2 + 1), c == 15, 0, 0);
    end
    for (int k = 0; k < 8; k++)
      add("gap_read", 0, 0, 0, 0, 1, 3'(k), 0, 8, 1, 1, 5'(2 * k + 2));
    add("flush_rel", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add("part", 1, 5'(i + 1), 0, 0, 0, 0, 1, 4'(i + 1), 0, 0, 0);
    add("flush_beat", 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add("stale5", 0, 0, 0, 0, 1, 5, 1, 0, 0, 1, 12);
    add("part4", 0, 0, 0, 0, 1, 4, 1, 0, 0, 1, 5);
    add("pre_a", 1, 10, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    add("pre_b", 1, 8, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    add("pre_c", 1, 6, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    add("pre_flush", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add("col_a", 1, 14, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    add("col_b", 1, 15, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    add("collide", 1, 13, 0, 0, 1, 2, 1, 3, 0, 1, 6);
    add("reread", 0, 0, 0, 0, 1, 2, 1, 3, 0, 1, 13);
    add("rd_hold", 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 13);

    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset.count", bus.count_o, 0);
    check("reset.poly_done", bus.poly_done_o, 0);
    check("reset.rd_valid", bus.rd_valid_o, 0);
    check("reset.rd_data", bus.rd_data_o, 0);
    check("reset.in_ready", bus.in_ready_o, 1);
`ifdef POLY_COLLECTOR_RANGE_CHECK_EN
    check("reset.range_err", bus.range_err_o, 0);
`endif
    $display("[TB] reset released");

    foreach (vecs[i]) apply(i, vecs[i]);

    // Reset mid-fill (count 3), with a read in flight so rd_valid is high.
    @(negedge clk);
    idle_inputs();
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 5'd20;
    bus.rd_en_i    = 1'b1;
    bus.rd_addr_i  = 3'd0;
    @(posedge clk);
    #1;
    check("midfill.count", bus.count_o, 4);
    check("midfill.rd_valid", bus.rd_valid_o, 1);
`ifdef POLY_COLLECTOR_RANGE_CHECK_EN
    check("midfill.range_err", bus.range_err_o, 1);
`endif
    $display("[TB] mid-fill beat 20 -> cnt=%0d", bus.count_o);
    #2;
    idle_inputs();
    reset_n = 1'b0;
    #1;
    check("async_rst.count", bus.count_o, 0);
    check("async_rst.poly_done", bus.poly_done_o, 0);
    check("async_rst.rd_valid", bus.rd_valid_o, 0);
    check("async_rst.rd_data", bus.rd_data_o, 0);
`ifdef POLY_COLLECTOR_RANGE_CHECK_EN
    check("async_rst.range_err", bus.range_err_o, 0);
`endif
    $display("[TB] async reset mid-cycle -> cnt=%0d rd_valid=%0d", bus.count_o, bus.rd_valid_o);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
